// File: rtl/settle_monitor_pkg.sv
// settle_monitor_pkg: shared FSM state type and error-width helper for the settle monitor.
package settle_monitor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE_OK, DONE_TO} state_t;
  // One extra bit lets v_meas - target and its magnitude be represented without overflow.
  function automatic int err_w(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/settle_band_cmp.sv
// settle_band_cmp: registered |v_meas - target| <= tol compare with a qualifying valid.
//   clk, rst_n        : clock, async active-low reset
//   flush             : drop any sample presented this cycle (vld stays low)
//   sample_en         : v_meas is a new time step
//   v_meas, target    : signed raw fixed-point, common exponent
//   tol               : unsigned tolerance, same exponent
//   hit, vld          : compare result for the last qualified sample, and its one-cycle strobe
module settle_band_cmp
  import settle_monitor_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    sample_en,
  input  logic signed [WIDTH-1:0] v_meas,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-1:0] tol,
  output logic                    hit,
  output logic                    vld
);
  localparam int EW = err_w(WIDTH);
  logic signed [EW-1:0] err;
  logic        [EW-1:0] mag;
  logic hit_d, hit_q, vld_d, vld_q;
  always_comb begin
    err   = EW'(v_meas) - EW'(target);
    // |err| <= 2^WIDTH-1, so the negation never overflows at EW bits.
    mag   = err[EW-1] ? -err : err;
    hit_d = sample_en ? (mag <= {1'b0, tol}) : hit_q;
    vld_d = sample_en & ~flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
      vld_q <= vld_d;
    end
  end
  assign hit = hit_q;
  assign vld = vld_q;
endmodule

// File: rtl/settle_monitor.sv
// settle_monitor: decides whether a sampled path output settles within tol of target, reporting settle step or timeout.
//   emu_clk, emu_rst_n   : emulator clock, async active-low reset
//   start                : arm / re-arm a measurement (wins over everything else that cycle)
//   sample_en, v_meas    : qualified path output sample
//   target, tol          : settle target and tolerance, stable while busy
//   busy                 : measurement running
//   settled, timeout     : sticky results, mutually exclusive
//   in_band              : compare result of the most recent qualified sample
//   settle_steps         : 0-based step of the first sample of the final in-band run
module settle_monitor
  import settle_monitor_pkg::*;
#(
  parameter int WIDTH     = 25,
  parameter int CNT_W     = 16,
  parameter int HOLD      = 8,
  parameter int MAX_STEPS = 1000
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst_n,
  input  logic                    start,
  input  logic                    sample_en,
  input  logic signed [WIDTH-1:0] v_meas,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-1:0] tol,
  output logic                    busy,
  output logic                    settled,
  output logic                    timeout,
  output logic                    in_band,
  output logic        [CNT_W-1:0] settle_steps
);
  logic hit, vld;
  state_t state_d, state_q;
  logic busy_d, busy_q, settled_d, settled_q, timeout_d, timeout_q, in_band_d, in_band_q;
  logic [CNT_W-1:0] steps_d, steps_q, elapsed_d, elapsed_q, run_d, run_q, run_nx, el_nx;
  settle_band_cmp #(.WIDTH(WIDTH)) u_cmp (
    .clk(emu_clk), .rst_n(emu_rst_n), .flush(start), .sample_en(sample_en),
    .v_meas(v_meas), .target(target), .tol(tol), .hit(hit), .vld(vld)
  );
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    settled_d = settled_q;
    timeout_d = timeout_q;
    in_band_d = in_band_q;
    steps_d   = steps_q;
    elapsed_d = elapsed_q;
    run_d     = run_q;
    run_nx    = hit ? run_q + CNT_W'(1) : '0;
    el_nx     = elapsed_q + CNT_W'(1);
    if (start) begin
      state_d   = RUN;
      busy_d    = 1'b1;
      settled_d = 1'b0;
      timeout_d = 1'b0;
      in_band_d = 1'b0;
      steps_d   = '0;
      elapsed_d = '0;
      run_d     = '0;
    end else if (vld) begin
      in_band_d = hit;
      if (state_q == RUN) begin
        steps_d   = (hit && run_q == '0) ? elapsed_q : steps_q;
        run_d     = run_nx;
        elapsed_d = el_nx;
        // Settling on the final allowed sample still counts as settled.
        if (run_nx == CNT_W'(HOLD)) begin
          state_d   = DONE_OK;
          busy_d    = 1'b0;
          settled_d = 1'b1;
        end else if (el_nx == CNT_W'(MAX_STEPS)) begin
          state_d   = DONE_TO;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      timeout_q <= 1'b0;
      in_band_q <= 1'b0;
      steps_q   <= '0;
      elapsed_q <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
      timeout_q <= timeout_d;
      in_band_q <= in_band_d;
      steps_q   <= steps_d;
      elapsed_q <= elapsed_d;
      run_q     <= run_d;
    end
  end
  assign busy         = busy_q;
  assign settled      = settled_q;
  assign timeout      = timeout_q;
  assign in_band      = in_band_q;
  assign settle_steps = steps_q;
endmodule

// File: tb/tb_settle_monitor.sv
// tb_settle_monitor: scoreboard bench for settle_monitor (WIDTH=16, HOLD=4, MAX_STEPS=20).
module tb_settle_monitor;
  localparam int W = 16, CW = 16, HOLD = 4, MAXS = 20;
  logic clk = 0, rst_n = 0, start = 0, sample_en = 0;
  logic signed [W-1:0] v_meas = 0, target = 0;
  logic [W-1:0] tol = 0;
  logic busy, settled, timeout, in_band;
  logic [CW-1:0] settle_steps;
  int total = 0, bad = 0, cyc = 0, fall_cyc = 0;
  bit fall_seen = 0;
  logic busy_prev = 0;
  typedef struct {int s; int t; int steps; int fall;} exp_t;
  exp_t sb[$];
  int seq[$];

  settle_monitor #(.WIDTH(W), .CNT_W(CW), .HOLD(HOLD), .MAX_STEPS(MAXS)) dut (
    .emu_clk(clk), .emu_rst_n(rst_n), .start(start), .sample_en(sample_en),
    .v_meas(v_meas), .target(target), .tol(tol), .busy(busy), .settled(settled),
    .timeout(timeout), .in_band(in_band), .settle_steps(settle_steps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy_prev === 1'b1 && busy === 1'b0 && !fall_seen) begin
      fall_seen = 1;
      fall_cyc  = cyc;
    end
    busy_prev = busy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_only(input logic signed [W-1:0] t, input logic [W-1:0] tl);
    target = t; tol = tl; start = 1; sample_en = 0;
    @(negedge clk);
    start = 0;
    foreach (seq[i]) begin
      sample_en = 1; v_meas = W'(seq[i]);
      @(negedge clk);
    end
    sample_en = 0;
  endtask

  task automatic run_seq(input string tag, input logic signed [W-1:0] t, input logic [W-1:0] tl,
                         input bit se0, input logic signed [W-1:0] v0);
    int run = 0, first = 0, endi = -1, s = 0, to = 0, d, mag;
    exp_t e;
    foreach (seq[i]) begin
      d   = seq[i] - int'(t);
      mag = d < 0 ? -d : d;
      if (mag <= int'(tl)) begin
        if (run == 0) first = i;
        run++;
      end else run = 0;
      if (run == HOLD) begin s = 1; endi = i; break; end
      if (i + 1 == MAXS) begin to = 1; endi = i; break; end
    end
    target = t; tol = tl; start = 1; sample_en = se0; v_meas = v0; fall_seen = 0;
    @(negedge clk);
    start = 0;
    foreach (seq[i]) begin
      sample_en = 1; v_meas = W'(seq[i]);
      @(negedge clk);
      if (i == endi) sb.push_back('{s, to, first, cyc + 1});
    end
    sample_en = 0;
    for (int k = 0; k < 10 && !fall_seen; k++) @(negedge clk);
    chk({tag, "_done"}, int'(fall_seen), 1);
    if (sb.size() == 0) chk({tag, "_sb"}, 0, 1);
    else begin
      e = sb.pop_front();
      chk({tag, "_settled"}, int'(settled), e.s);
      chk({tag, "_timeout"}, int'(timeout), e.t);
      chk({tag, "_steps"}, int'(settle_steps), e.steps);
      chk({tag, "_fall_cyc"}, fall_cyc, e.fall);
      chk({tag, "_busy"}, int'(busy), 0);
    end
  endtask

  task automatic probe(input string tag, input logic signed [W-1:0] v, input logic signed [W-1:0] t,
                       input logic [W-1:0] tl, input int exp);
    target = t; tol = tl; v_meas = v; sample_en = 1;
    @(negedge clk);
    sample_en = 0;
    @(negedge clk);
    chk(tag, int'(in_band), exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", int'({busy, settled, timeout, in_band}), 0);
    chk("rst_steps", int'(settle_steps), 0);
    rst_n = 1;
    @(negedge clk);

    seq = '{0, 500, 900, 995, 1003, 1008, 998, 1001, 1000, 999};
    run_seq("basic", 1000, 10, 0, 0);

    probe("ext_hit", 32767, -32768, 65535, 1);
    probe("ext_miss", 32767, -32768, 65534, 0);
    probe("edge_hi_in", 1010, 1000, 10, 1);
    probe("edge_hi_out", 1011, 1000, 10, 0);
    probe("edge_lo_in", 990, 1000, 10, 1);
    probe("edge_lo_out", 989, 1000, 10, 0);
    chk("done_hold_settled", int'(settled), 1);
    chk("done_hold_steps", int'(settle_steps), 3);

    seq = {};
    for (int i = 0; i < 25; i++) seq.push_back(0);
    run_seq("tmo", 1000, 10, 0, 0);

    seq = '{0, 0, 1005, 995, 1010, 1011, 1000, 990, 1010, 1002, 1000, 1000};
    run_seq("ring", 1000, 10, 0, 0);

    seq = '{0, 0, 0, 0, 1000, 1000, 1000};
    drive_only(1000, 10);
    chk("restart_busy", int'(busy), 1);
    seq = '{0, 1000, 1000, 1000, 1000, 1000};
    run_seq("restart", 1000, 10, 1, 1000);

    seq = '{0, 1000, 1000};
    drive_only(1000, 10);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_inband", int'(in_band), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out", int'({busy, settled, timeout, in_band}), 0);
    chk("async_rst_steps", int'(settle_steps), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    seq = '{1000, 1000, 1000, 1000, 1000};
    run_seq("post_rst", 1000, 10, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/settle_monitor.md
Name: settle_monitor

Overview:
- Observer for the output end of an emulated analog path (filter, tf block). Takes fixed-point samples of the path output and decides whether the output has settled to a target value within a tolerance.
- Reports settle time in emulator time steps, or a timeout.
- Sits beside the filter in the emulator's testbench/probe logic. Stimulus drives the filter input; this block reads the filter output and produces pass/fail plus settle time for the host.

Parameters:
- WIDTH, 25, bit width of the svreal fixed-point raw value. v_meas and target share one exponent, aligned by the caller.
- CNT_W, 16, width of the elapsed-step and settle-time counters.
- HOLD, 8, number of consecutive in-band samples required to declare settled (1..2^CNT_W-1).
- MAX_STEPS, 1000, number of sample strobes after start before timeout (HOLD <= MAX_STEPS < 2^CNT_W).

Ports:
- emu_clk, in, 1, emulator clock.
- emu_rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse: arm or re-arm a measurement.
- sample_en, in, 1, qualifies v_meas as a new emulator time step.
- v_meas, in, WIDTH signed, filter output raw fixed-point.
- target, in, WIDTH signed, expected final value (same exponent as v_meas), held stable while busy.
- tol, in, WIDTH unsigned, allowed absolute error (same exponent), held stable while busy.
- busy, out, 1, measurement in progress.
- settled, out, 1, sticky: settle criterion met.
- timeout, out, 1, sticky: MAX_STEPS reached without settling.
- in_band, out, 1, registered |v_meas - target| <= tol for the most recent qualified sample.
- settle_steps, out, CNT_W, step index (0-based since start) of the first sample of the final in-band run; valid when settled=1.

Behaviour:
- Reset (emu_rst_n=0, async): state IDLE. busy, settled, timeout and in_band are 0. settle_steps, elapsed count, run count and pipeline valid are 0.
- Compare stage (sub-module), 1-cycle latency:
  - err = sext(v_meas) - sext(target) at WIDTH+1 bits; mag = |err| at WIDTH+1 bits with no overflow.
  - hit = mag <= zext(tol).
  - Registered on sample_en along with vld_q = sample_en and the sample index.
- in_band updates only on cycles where vld_q=1 and holds otherwise. It updates in all states except that start clears it to 0.
- States:
  - IDLE: wait for start.
  - RUN: on start -> busy=1, clear elapsed, run, settled, timeout and settle_steps; clear vld_q so an in-flight sample is dropped.
  - In RUN, each vld_q cycle:
    - If hit and run==0: record settle_steps=elapsed.
    - If hit: run=run+1. Else: run=0.
    - Then elapsed=elapsed+1.
  - RUN -> DONE_OK when the updated run reaches HOLD: settled=1, busy=0 in the following cycle.
  - RUN -> DONE_TO when the updated elapsed reaches MAX_STEPS and settle did not occur on the same sample: timeout=1, busy=0. If both conditions hit on the same sample, settled wins.
  - DONE_OK / DONE_TO: outputs hold until the next start.
- start in any state (including mid-RUN) restarts the measurement; start has priority over a same-cycle settle or timeout.
- sample_en while IDLE or DONE: compare still runs and in_band tracks, but no counters change.
- Counters never wrap, because elapsed is bounded by MAX_STEPS < 2^CNT_W.
- Exactly one of settled/timeout is ever 1. Both stay 0 while busy.

Decomposition:
- Package settle_monitor_pkg:
  - state enum (IDLE, RUN, DONE_OK, DONE_TO).
  - localparam helper for the WIDTH+1 error width.
- Sub-module settle_band_cmp: registered sign-extend, subtract, abs and compare. Outputs hit and vld_q.
- The FSM and counters stay in settle_monitor.

Test Plan:
- WIDTH=16, HOLD=4, MAX_STEPS=20, target=1000, tol=10; start, then v_meas = 0, 500, 900, 995, 1003, 1008, 998, ... every cycle -> settled=1 after 4th in-band sample, settle_steps=3, busy falls 2 cycles after that sample's strobe.
- Same setup, v_meas stays 0 -> timeout=1 after 20th strobe, settled=0, settle_steps=0.
- Ringing: in-band 3 samples (steps 2-4), out at step 5 (v_meas=1011), in-band steps 6-9 -> settled, settle_steps=6. Also check the boundary at mag==tol: v_meas=1010 counts as in-band.
- Extremes: target=-32768, v_meas=32767, tol=65535 -> hit=1 with no overflow. Same target with tol=65534 -> hit=0.
- Restart mid-RUN: start at step 7 while a sample is in flight -> counters clear, the in-flight sample is ignored, a fresh measurement yields settle_steps relative to the new start.
- Async reset asserted mid-RUN with no clock edge -> all outputs 0 immediately. Deassert, then start -> normal operation.
